affine_addr_gen: RTL

Upstream address sequencer for the memory core's arbitrary-address read path. It walks an affine iteration space of up to six dimensions, producing `starting_addr + Σ count_i·stride_i`, and emits one address per accepted handshake. Its output drives `addr_in`/`ren_in` of the memory core in tile mode. Configuration is latched at `start`, so A-QED original and duplicate runs replay identical sequences.

---
 rtl/affine_addr_gen_pkg.sv | 30 +++
 rtl/addr_dim_counter.sv | 56 +++++
 rtl/affine_addr_gen.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/affine_addr_gen_pkg.sv
// Shared types and widths for the affine address generator.
// Imported by the generator, its dimension counters and the memory-core top.
package affine_addr_gen_pkg;

  localparam int MAX_DIMS   = 6;
  localparam int AG_ADDR_W  = 16;
  localparam int AG_RANGE_W = 32;

  typedef enum logic [1:0] {
    AG_IDLE,
    AG_RUN,
    AG_DONE
  } ag_state_t;

  // Active dimension count: 0 means one loop, large values saturate.
  function automatic logic [3:0] clamp_dims(
    input logic [3:0] d,
    input int         n
  );
    logic [3:0] r;
    if (d == 4'd0)
      r = 4'd1;
    else if (d > 4'(n))
      r = 4'(n);
    else
      r = d;
    return r;
  endfunction

endpackage

// File: rtl/addr_dim_counter.sv
// One loop dimension: trip counter plus running count*stride offset.
// Carries out through wrap; disabled dimensions sit at zero.
module addr_dim_counter
  import affine_addr_gen_pkg::*;
#(
  parameter int ADDR_W  = AG_ADDR_W,
  parameter int RANGE_W = AG_RANGE_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               clr,
  input  logic               inc,
  input  logic               enable,
  input  logic [RANGE_W-1:0] range,
  input  logic [ADDR_W-1:0]  stride,
  output logic [ADDR_W-1:0]  offset,
  output logic [ADDR_W-1:0]  offset_nxt,
  output logic               wrap
);

  logic [RANGE_W-1:0] count;
  logic [RANGE_W-1:0] count_nxt;

  assign wrap = enable && (count == range - RANGE_W'(1));

  // Next count/offset: accumulate stride, clear on wrap.
  always_comb begin
    count_nxt  = count;
    offset_nxt = offset;
    if (clr || !enable) begin
      count_nxt  = '0;
      offset_nxt = '0;
    end else if (inc) begin
      if (wrap) begin
        count_nxt  = '0;
        offset_nxt = '0;
      end else begin
        count_nxt  = count + RANGE_W'(1);
        offset_nxt = offset + stride;
      end
    end
  end

  // Counter state, frozen while the clock enable is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      offset <= '0;
    end else if (clk_en) begin
      count  <= count_nxt;
      offset <= offset_nxt;
    end
  end

endmodule

// File: rtl/affine_addr_gen.sv
// Affine address sequencer: base + sum(count_i*stride_i), one per handshake.
// Optional embedded assertions: define AFFINE_ADDR_GEN_SVA_EN.
module affine_addr_gen
  import affine_addr_gen_pkg::*;
#(
  parameter int NUM_DIMS = MAX_DIMS,
  parameter int ADDR_W   = AG_ADDR_W,
  parameter int RANGE_W  = AG_RANGE_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clk_en,
  input  logic                             flush,
  input  logic                             start,
  input  logic [3:0]                       dimensionality,
  input  logic [ADDR_W-1:0]                starting_addr,
  input  logic [NUM_DIMS-1:0][ADDR_W-1:0]  stride,
  input  logic [NUM_DIMS-1:0][RANGE_W-1:0] range,
  input  logic [RANGE_W-1:0]               iter_cnt,
  output logic [ADDR_W-1:0]                addr_out,
  output logic                             addr_valid,
  input  logic                             addr_ready,
  output logic                             last,
  output logic                             done,
  output logic                             busy
);

  ag_state_t                    state;
  logic [RANGE_W-1:0]           remaining;
  logic [ADDR_W-1:0]            base_q;
  logic [3:0]                   dims_q;
  logic [NUM_DIMS-1:0][ADDR_W-1:0]  stride_q;
  logic [NUM_DIMS-1:0][RANGE_W-1:0] range_q;

  logic                         xfer;
  logic                         launch;
  logic                         step;
  logic                         clr;
  logic [NUM_DIMS:0]            carry;
  logic [NUM_DIMS-1:0]          wrap;
  logic [NUM_DIMS-1:0]          enable;
  logic [NUM_DIMS-1:0][ADDR_W-1:0] offs;
  logic [NUM_DIMS-1:0][ADDR_W-1:0] offs_nxt;
  logic [ADDR_W-1:0]            addr_nxt;

  assign xfer   = addr_valid && addr_ready && clk_en;
  assign launch = clk_en && !flush && (state == AG_IDLE) && start;
  assign step   = xfer && !flush;
  assign clr    = (clk_en && flush) || launch;
  assign busy   = (state != AG_IDLE);

  assign carry[0] = step;

  for (genvar i = 0; i < NUM_DIMS; i++) begin : g_dim
    assign enable[i]  = (4'(i) < dims_q);
    assign carry[i+1] = carry[i] && wrap[i];

    addr_dim_counter #(
      .ADDR_W  (ADDR_W),
      .RANGE_W (RANGE_W)
    ) u_dim (
      .clk        (clk),
      .rst_n      (reset),
      .clk_en     (clk_en),
      .clr        (clr),
      .inc        (carry[i]),
      .enable     (enable[i]),
      .range      (range_q[i]),
      .stride     (stride_q[i]),
      .offset     (offs[i]),
      .offset_nxt (offs_nxt[i]),
      .wrap       (wrap[i])
    );
  end

  // Address after the pending transfer, modulo 2^ADDR_W.
  always_comb begin
    addr_nxt = base_q;
    for (int i = 0; i < NUM_DIMS; i++)
      addr_nxt = addr_nxt + offs_nxt[i];
  end

  // Configuration snapshot taken when a sequence launches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q   <= '0;
      dims_q   <= 4'd1;
      stride_q <= '0;
      range_q  <= '0;
    end else if (launch) begin
      base_q   <= starting_addr;
      dims_q   <= clamp_dims(dimensionality, NUM_DIMS);
      stride_q <= stride;
      for (int i = 0; i < NUM_DIMS; i++)
        range_q[i] <= (range[i] == '0) ? RANGE_W'(1) : range[i];
    end
  end

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= AG_IDLE;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      last       <= 1'b0;
      done       <= 1'b0;
      remaining  <= '0;
    end else if (clk_en) begin
      done <= 1'b0;
      if (flush) begin
        state      <= AG_IDLE;
        addr_valid <= 1'b0;
        last       <= 1'b0;
      end else begin
        unique case (state)
          AG_IDLE: begin
            if (start) begin
              remaining <= iter_cnt;
              if (iter_cnt == '0) begin
                state <= AG_DONE;
                done  <= 1'b1;
              end else begin
                state      <= AG_RUN;
                addr_out   <= starting_addr;
                addr_valid <= 1'b1;
                last       <= (iter_cnt == RANGE_W'(1));
              end
            end
          end
          AG_RUN: begin
            if (xfer) begin
              if (last) begin
                state      <= AG_DONE;
                done       <= 1'b1;
                addr_valid <= 1'b0;
                last       <= 1'b0;
                remaining  <= '0;
              end else begin
                addr_out  <= addr_nxt;
                remaining <= remaining - RANGE_W'(1);
                last      <= (remaining == RANGE_W'(2));
              end
            end
          end
          AG_DONE: begin
            state <= AG_IDLE;
          end
          default: begin
            state      <= AG_IDLE;
            addr_valid <= 1'b0;
            last       <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef AFFINE_ADDR_GEN_SVA_EN
  logic [RANGE_W-1:0] sva_xfers;
  logic [RANGE_W-1:0] sva_iter;

  // Transfers seen since the last launch, for the completion check.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sva_xfers <= '0;
      sva_iter  <= '0;
    end else if (launch) begin
      sva_xfers <= '0;
      sva_iter  <= iter_cnt;
    end else if (step) begin
      sva_xfers <= sva_xfers + RANGE_W'(1);
    end
  end

  a_hold: assert property (@(posedge clk) disable iff (!reset)
    addr_valid && !xfer && !(clk_en && flush)
    |=> addr_valid && $stable(addr_out) && $stable(last));

  a_idle: assert property (@(posedge clk) disable iff (!reset)
    (state != AG_RUN) |-> !addr_valid);

  a_pulse: assert property (@(posedge clk) disable iff (!reset)
    done && clk_en |=> !done);

  a_count: assert property (@(posedge clk) disable iff (!reset)
    done |-> (sva_xfers == sva_iter));
`endif

endmodule
